mips_mc_controller: RTL and testbench

MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

---
 rtl/mips_mc_pkg.sv | 47 ++++
 rtl/mips_mc_controller_decode.sv | 106 ++++++++++
 rtl/mips_mc_controller.sv | 65 ++++++
 tb/tb_mips_mc_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared encodings for the multi-cycle MIPS controller.
package mips_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Unknown opcodes map to FETCH, which doubles as the illegal-op test.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE: return S_R_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_J: return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
      default: return S_FETCH;
    endcase
  endfunction

  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
  endfunction
endpackage

// File: rtl/mips_mc_controller_decode.sv
// mips_mc_decode: per-state control output decode (combinational).
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        ext_type,
  output logic        instr_done,
  output logic        illegal_op
);
  always_comb begin
    pc_en = 1'b0;
    ir_write = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRC_B_RT;
    alu_op = ALU_ADD;
    pc_source = PC_ALU;
    ext_type = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write = ready;
        pc_en = ready;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        ext_type = 1'b1;
        illegal_op = decode_next(opcode) == S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        ext_type = 1'b1;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord = 1'b1;
        instr_done = ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_en = opcode == OP_BNE ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source = PC_JUMP;
        pc_en = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op = i_alu_op(opcode);
        ext_type = !(opcode == OP_ANDI || opcode == OP_ORI);
      end
      S_I_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle MIPS control FSM.
// Define MC_MEM_WAIT_EN to enable the mem_ready wait handshake.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        ext_type,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state
);
  state_t st, nxt;
  logic ready, raw_pc_en, raw_ir_write, raw_done, raw_illegal;
`ifdef MC_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = mem_ready | 1'b1;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) st <= S_FETCH;
    else st <= nxt;
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH: nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = decode_next(opcode);
      S_MEM_ADDR: nxt = opcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: nxt = ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC: nxt = S_R_WB;
      S_I_EXEC: nxt = S_I_WB;
      default: nxt = S_FETCH;
    endcase
  end
  mips_mc_decode u_decode (
    .state(st), .opcode(opcode), .zero(zero), .ready(ready),
    .pc_en(raw_pc_en), .ir_write(raw_ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .ext_type(ext_type),
    .instr_done(raw_done), .illegal_op(raw_illegal)
  );
  // Load and pulse outputs are held off while reset is asserted.
  assign pc_en = raw_pc_en & reset;
  assign ir_write = raw_ir_write & reset;
  assign instr_done = raw_done & reset;
  assign illegal_op = raw_illegal & reset;
  assign state = st;
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed scenario checks for the multi-cycle controller.
module tb_mips_mc_controller;
  logic clock, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
  logic alu_src_a, ext_type, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  int errors = 0, checks = 0;

  mips_mc_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .ext_type(ext_type),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if ({mem_read, iord, alu_src_a, alu_src_b, alu_op, pc_source} !== 10'b1_0_0_01_000_00) begin
      errors++; $display("FAIL reset_fetch_ctl: got %b want 1000100000", {mem_read, iord, alu_src_a, alu_src_b, alu_op, pc_source}); end
    checks++; if ({ir_write, pc_en, instr_done, illegal_op} !== 4'b0000) begin
      errors++; $display("FAIL reset_gated: got %b want 0000", {ir_write, pc_en, instr_done, illegal_op}); end
    @(posedge clock); #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_hold_state: got %0d want 0", state); end
    @(posedge clock); #1 reset = 1'b1; #1;
    checks++; if ({ir_write, pc_en} !== 2'b11) begin errors++; $display("FAIL release_fetch: got %b want 11", {ir_write, pc_en}); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== exp[i]) begin errors++; $display("FAIL mid_pre_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      if (i < 2) @(negedge clock);
    end
    checks++; if (alu_op !== 3'b010) begin errors++; $display("FAIL r_exec_aluop: got %b want 010", alu_op); end
    reset = 1'b0; #1;
    checks++; if ({state, reg_write} !== 5'b0000_0) begin errors++; $display("FAIL mid_reset_async: got %b want 00000", {state, reg_write}); end
    @(posedge clock); #1;
    checks++; if ({state, reg_write, mem_write} !== 6'b0) begin errors++; $display("FAIL mid_reset_hold: got %b want 000000", {state, reg_write, mem_write}); end
    @(posedge clock); #1 reset = 1'b1; #1;
    checks++; if ({state, ir_write} !== 5'b0000_1) begin errors++; $display("FAIL mid_release: got %b want 00001", {state, ir_write}); end
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== exp[i]) begin errors++; $display("FAIL r_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      if (i == 3) begin
        checks++; if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1101) begin
          errors++; $display("FAIL r_wb: got %b want 1101", {reg_write, reg_dst, mem_to_reg, instr_done}); end
      end
      @(negedge clock);
    end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL r_latency: got %0d want 0", state); end
  endtask

  task automatic test_lw;
    logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state !== exp[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      checks++; if (instr_done !== (i == 4)) begin errors++; $display("FAIL lw_done[%0d]: got %b want %b", i, instr_done, i == 4); end
      if (i == 1) begin
        checks++; if ({illegal_op, alu_src_b, ext_type} !== 4'b0111) begin errors++; $display("FAIL lw_decode: got %b want 0111", {illegal_op, alu_src_b, ext_type}); end
      end
      if (i == 2) begin
        checks++; if ({alu_src_a, alu_src_b, alu_op, ext_type} !== 7'b1_10_000_1) begin errors++; $display("FAIL lw_addr: got %b want 1100001", {alu_src_a, alu_src_b, alu_op, ext_type}); end
      end
      if (i == 3) begin
        checks++; if ({mem_read, iord, reg_write} !== 3'b110) begin errors++; $display("FAIL lw_read: got %b want 110", {mem_read, iord, reg_write}); end
      end
      if (i == 4) begin
        checks++; if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin errors++; $display("FAIL lw_wb: got %b want 110", {reg_write, mem_to_reg, reg_dst}); end
      end
      @(negedge clock);
    end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_latency: got %0d want 0", state); end
  endtask

  task automatic test_branch;
    logic [5:0] ops [4] = '{6'b000100, 6'b000101, 6'b000100, 6'b000101};
    logic zs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic want [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp [3] = '{4'd0, 4'd1, 4'd8};
    for (int c = 0; c < 4; c++) begin
      opcode = ops[c]; zero = zs[c];
      for (int i = 0; i < 3; i++) begin
        checks++; if (state !== exp[i]) begin errors++; $display("FAIL br%0d_state[%0d]: got %0d want %0d", c, i, state, exp[i]); end
        if (i == 2) begin
          checks++; if (pc_en !== want[c]) begin errors++; $display("FAIL br%0d_pc_en: got %b want %b", c, pc_en, want[c]); end
          checks++; if ({pc_source, alu_op, alu_src_a, alu_src_b, instr_done} !== 9'b01_001_1_00_1) begin
            errors++; $display("FAIL br%0d_ctl: got %b want 010011001", c, {pc_source, alu_op, alu_src_a, alu_src_b, instr_done}); end
        end
        @(negedge clock);
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL br%0d_latency: got %0d want 0", c, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump;
    logic [3:0] exp [3] = '{4'd0, 4'd1, 4'd9};
    opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== exp[i]) begin errors++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, exp[i]); end
      if (i == 2) begin
        checks++; if ({pc_source, pc_en, instr_done} !== 4'b1011) begin errors++; $display("FAIL j_ctl: got %b want 1011", {pc_source, pc_en, instr_done}); end
      end
      @(negedge clock);
    end
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL j_latency: got %0d want 0", state); end
  endtask

  task automatic test_itype;
    logic [5:0] ops [4] = '{6'b001100, 6'b001101, 6'b001010, 6'b001000};
    logic [2:0] aop [4] = '{3'b011, 3'b100, 3'b101, 3'b000};
    logic ext [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
    for (int c = 0; c < 4; c++) begin
      opcode = ops[c];
      for (int i = 0; i < 4; i++) begin
        checks++; if (state !== exp[i]) begin errors++; $display("FAIL i%0d_state[%0d]: got %0d want %0d", c, i, state, exp[i]); end
        if (i == 2) begin
          checks++; if ({alu_op, ext_type} !== {aop[c], ext[c]}) begin errors++; $display("FAIL i%0d_exec: got %b want %b", c, {alu_op, ext_type}, {aop[c], ext[c]}); end
          checks++; if ({alu_src_a, alu_src_b, reg_write} !== 4'b1100) begin errors++; $display("FAIL i%0d_src: got %b want 1100", c, {alu_src_a, alu_src_b, reg_write}); end
        end
        if (i == 3) begin
          checks++; if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin errors++; $display("FAIL i%0d_wb: got %b want 1001", c, {reg_write, reg_dst, mem_to_reg, instr_done}); end
        end
        @(negedge clock);
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL i%0d_latency: got %0d want 0", c, state); end
    end
  endtask

  task automatic test_illegal;
    opcode = 6'b111111;
    checks++; if ({state, illegal_op} !== 5'b0000_0) begin errors++; $display("FAIL ill_fetch: got %b want 00000", {state, illegal_op}); end
    @(negedge clock);
    checks++; if ({state, illegal_op, reg_write, mem_write} !== 7'b0001_1_0_0) begin errors++; $display("FAIL ill_decode: got %b want 0001100", {state, illegal_op, reg_write, mem_write}); end
    @(negedge clock);
    checks++; if ({state, illegal_op, reg_write, mem_write} !== 7'b0) begin errors++; $display("FAIL ill_return: got %b want 0000000", {state, illegal_op, reg_write, mem_write}); end
  endtask

  task automatic test_mem_wait;
    opcode = 6'b101011;
`ifdef MC_MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({state, ir_write, pc_en, mem_read} !== 7'b0000_001) begin errors++; $display("FAIL fetch_wait[%0d]: got %b want 0000001", i, {state, ir_write, pc_en, mem_read}); end
      @(negedge clock);
    end
    mem_ready = 1'b1; #1;
    checks++; if ({state, ir_write, pc_en} !== 6'b0000_11) begin errors++; $display("FAIL fetch_ready: got %b want 000011", {state, ir_write, pc_en}); end
    @(negedge clock);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL sw_decode: got %0d want 1", state); end
    @(negedge clock);
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL sw_addr: got %0d want 2", state); end
    mem_ready = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin mem_ready = 1'b1; #1; end
      checks++; if ({state, mem_write, iord} !== 6'b0101_11) begin errors++; $display("FAIL sw_wait[%0d]: got %b want 010111", k, {state, mem_write, iord}); end
      checks++; if (instr_done !== (k == 3)) begin errors++; $display("FAIL sw_done[%0d]: got %b want %b", k, instr_done, k == 3); end
      @(negedge clock);
    end
`else
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (state !== (i == 3 ? 4'd5 : 4'(i))) begin errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, i == 3 ? 5 : i); end
      if (i == 0) begin
        checks++; if ({ir_write, pc_en} !== 2'b11) begin errors++; $display("FAIL sw_fetch_noready: got %b want 11", {ir_write, pc_en}); end
      end
      if (i == 3) begin
        checks++; if ({mem_write, iord, instr_done} !== 3'b111) begin errors++; $display("FAIL sw_write: got %b want 111", {mem_write, iord, instr_done}); end
      end
      @(negedge clock);
    end
    mem_ready = 1'b1;
`endif
    checks++; if ({state, mem_write} !== 5'b0) begin errors++; $display("FAIL sw_latency: got %b want 00000", {state, mem_write}); end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_lw;
    test_branch;
    test_jump;
    test_itype;
    test_illegal;
    test_mem_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
